hazard_unit: RTL
================

# hazard_unit

Pipeline hazard unit for the 5-stage MIPS core. It consumes the staged control bits the controller produces (regwrite, memtoreg, branch, jump) together with register addresses from the datapath. It drives the stall, flush and forwarding selects back into both: flushE clears the controller's E-stage control register. A registered memory-wait state machine freezes the pipeline while data memory is not ready, and latches a sticky error on timeout.

## Interface
- `MEM_TIMEOUT`, default 16: maximum consecutive not-ready cycles before error; legal range 2–255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `rsD`, `rtD`, `rsE`, `rtE`  in  5 each  source registers in D and E.
- `writeregE`, `writeregM`, `writeregW`  in  5 each  destination register per stage.
- `regwriteE`, `regwriteM`, `regwriteW`  in  1 each  stage write enables.
- `memtoregE`, `memtoregM`  in  1 each  load in E / M.
- `branchD`, `jumpD`, `pcsrcD`  in  1 each  D-stage branch, jump, branch-taken.
- `memenM`  in  1  data-memory access active in M.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `stallF`, `stallD`, `stallE`, `stallM`  out  1 each  hold the stage register.
- `flushD`, `flushE`, `flushW`  out  1 each  clear the stage register (bubble).
- `forwardAD`, `forwardBD`  out  1 each  D-stage comparator operand from M.
- `forwardAE`, `forwardBE`  out  2 each  E-stage ALU operand select.
- `mem_err`  out  1  sticky memory timeout flag.

## Operation
- Register 0 never matches: every compare below also requires the address to be nonzero.
- forwardAE: 2'b10 if regwriteM and writeregM==rsE; otherwise 2'b01 if regwriteW and writeregW==rsE; otherwise 2'b00. M has priority over W. forwardBE is the same using rtE.
- forwardAD = regwriteM and writeregM==rsD. forwardBD uses rtD.
- lwstall = memtoregE and regwriteE and writeregE ∈ {rsD, rtD}.
- branchstall = branchD and ((regwriteE and writeregE ∈ {rsD, rtD}) or (memtoregM and writeregM ∈ {rsD, rtD})).
- memstall:
  - in IDLE: memenM and not mem_ready;
  - in WAIT: not mem_ready;
  - in ERR: 0.
- stallF = stallD = lwstall or branchstall or memstall.
- stallE = stallM = memstall.
- flushW = memstall.
- flushE = (lwstall or branchstall) and not memstall. memstall has priority so the E-stage instruction is never lost.
- flushD = (jumpD or pcsrcD) and not stallD.
- Memory-wait FSM, states IDLE, WAIT, ERR. It has an 8-bit wait counter.
  - IDLE → WAIT when memenM and not mem_ready. The counter is loaded with 1.
  - WAIT → IDLE when mem_ready. The counter is cleared.
  - WAIT → ERR when not mem_ready and counter == MEM_TIMEOUT-1. mem_err is set.
  - Otherwise WAIT stays in WAIT and the counter increments.
  - ERR is absorbing until rst. In ERR, mem_err=1 and memstall=0, so the pipeline drains.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and the FSM state, valid in the same cycle. The controller's E-stage register samples flushE at the next edge.
- Reset: FSM in IDLE, counter 0, mem_err 0. Stall, flush and forward outputs then follow the inputs, e.g. all 0 with all-zero inputs.
- Total stall length for an access with mem_ready arriving N cycles after memenM: N cycles.
  - N=0 gives no stall.
  - For N ≥ MEM_TIMEOUT, the stall lasts exactly MEM_TIMEOUT cycles, then ERR.
- mem_ready in the same cycle as the timeout compare wins: WAIT → IDLE and no error.
- rst during WAIT or ERR returns to IDLE at that edge and clears mem_err.
- lwstall and branchstall together produce a single stall cycle with flushE=1.

## Configuration
- `HAZARD_PERF_CNT_EN`: when defined, adds two output ports.
  - `stall_cycles` (out, 32): counts cycles with stallF=1.
  - `flush_cycles` (out, 32): counts cycles with flushE=1.
  - Both saturate at 32'hFFFFFFFF and are cleared by rst.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Package `hazard_pkg` holds:
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - the memwait state encoding (IDLE, WAIT, ERR);
  - the counter width 8.
- One sub-module, `hazard_memwait`.
  - Contains the FSM and counter.
  - Inputs: clk, rst, memenM, mem_ready. Outputs: memstall, mem_err.
- Forwarding and stall logic stay in the top level.

## Test plan
- writeregM=5, regwriteM=1, writeregW=5, regwriteW=1, rsE=5 → forwardAE=2'b10. With regwriteM=0 → 2'b01. With rsE=0, all writeregs 0 → 2'b00.
- memtoregE=1, regwriteE=1, writeregE=8, rtD=8 for one cycle → stallF=stallD=flushE=1 that cycle, stallE=0. The next cycle, with E now a bubble → all 0.
- branchD=1, memtoregM=1, writeregM=3, rsD=3 → stallD=1, flushE=1, forwardAD=1.
- memenM=1, mem_ready low 3 cycles then high → memstall high exactly 3 cycles, flushE=0 throughout, FSM back in IDLE, mem_err=0.
- MEM_TIMEOUT=4, mem_ready held low → stall 4 cycles, mem_err=1 from the 5th cycle, stalls 0. Assert rst for one cycle → mem_err=0, IDLE.
- jumpD=1 with no hazard → flushD=1. jumpD=1 with lwstall → flushD=0, stallD=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: forward selects,
// memory-wait state encoding, wait-counter width and a register-match helper.
package hazard_pkg;

   localparam int CNT_W = 8;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      ERR  = 2'b10
   } memwait_state_t;

   // Register 0 is hard-wired, so a write to it never creates a dependency.
   function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
      return (dst != 5'd0) && (dst == src);
   endfunction

endpackage

// File: rtl/hazard_if.sv
// Pipeline <-> hazard unit bundle. The master side (controller/datapath)
// drives register addresses and staged control bits; the slave side
// (hazard_unit) returns stall, flush and forwarding selects.
interface hazard_if;

   logic [4:0] rsD, rtD, rsE, rtE;
   logic [4:0] writeregE, writeregM, writeregW;
   logic       regwriteE, regwriteM, regwriteW;
   logic       memtoregE, memtoregM;
   logic       branchD, jumpD, pcsrcD;
   logic       memenM, mem_ready;

   logic       stallF, stallD, stallE, stallM;
   logic       flushD, flushE, flushW;
   logic       forwardAD, forwardBD;
   logic [1:0] forwardAE, forwardBE;
   logic       mem_err;

   modport master (
      output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
             regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
             branchD, jumpD, pcsrcD, memenM, mem_ready,
      input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
             forwardAD, forwardBD, forwardAE, forwardBE, mem_err
   );

   modport slave (
      input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
             regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
             branchD, jumpD, pcsrcD, memenM, mem_ready,
      output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
             forwardAD, forwardBD, forwardAE, forwardBE, mem_err
   );

endinterface

// File: rtl/hazard_memwait.sv
// Memory-wait FSM: freezes the pipeline while data memory is not ready and
// moves to an absorbing error state after MEM_TIMEOUT consecutive stall cycles.
module hazard_memwait
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic memenM,
   input  logic mem_ready,
   output logic memstall,
   output logic mem_err
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);

   memwait_state_t   state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   // State and wait-counter registers.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state, counter update and stall request.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      state_nxt = state;
      cnt_nxt   = cnt;
      memstall  = 1'b0;
      unique case (state)
         IDLE: begin
            memstall = memenM && !mem_ready;
            if (memenM && !mem_ready) begin
               state_nxt = WAIT;
               cnt_nxt   = CNT_W'(1);
            end
         end
         WAIT: begin
            memstall = !mem_ready;
            if (mem_ready) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == LAST_CNT) begin
               state_nxt = ERR;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ERR: memstall = 1'b0;
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign mem_err = (state == ERR);

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding selects, load-use
// and branch stalls, control flushes, and the memory-wait freeze.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall/flush cycle counters.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic     clk,
   input  logic     rst,
   hazard_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_cycles
`endif
);

   logic memstall;
   logic lwstall, branchstall, stall_fd, flush_e;

   hazard_memwait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_memwait (
      .clk       (clk),
      .rst       (rst),
      .memenM    (hz.memenM),
      .mem_ready (hz.mem_ready),
      .memstall  (memstall),
      .mem_err   (hz.mem_err)
   );

   // Forwarding selects; M has priority over W because it is the younger result.
   always_comb begin
      hz.forwardAE = FWD_RF;
      hz.forwardBE = FWD_RF;
      if (hz.regwriteM && reg_match(hz.writeregM, hz.rsE))      hz.forwardAE = FWD_M;
      else if (hz.regwriteW && reg_match(hz.writeregW, hz.rsE)) hz.forwardAE = FWD_W;
      if (hz.regwriteM && reg_match(hz.writeregM, hz.rtE))      hz.forwardBE = FWD_M;
      else if (hz.regwriteW && reg_match(hz.writeregW, hz.rtE)) hz.forwardBE = FWD_W;
      hz.forwardAD = hz.regwriteM && reg_match(hz.writeregM, hz.rsD);
      hz.forwardBD = hz.regwriteM && reg_match(hz.writeregM, hz.rtD);
   end

   // Stall and flush generation; a memory freeze must not flush E or its instruction is lost.
   always_comb begin
      lwstall     = hz.memtoregE && hz.regwriteE &&
                    (reg_match(hz.writeregE, hz.rsD) || reg_match(hz.writeregE, hz.rtD));
      branchstall = hz.branchD &&
                    ((hz.regwriteE && (reg_match(hz.writeregE, hz.rsD) ||
                                       reg_match(hz.writeregE, hz.rtD))) ||
                     (hz.memtoregM && (reg_match(hz.writeregM, hz.rsD) ||
                                       reg_match(hz.writeregM, hz.rtD))));
      stall_fd    = lwstall || branchstall || memstall;
      flush_e     = (lwstall || branchstall) && !memstall;
      hz.stallF   = stall_fd;
      hz.stallD   = stall_fd;
      hz.stallE   = memstall;
      hz.stallM   = memstall;
      hz.flushW   = memstall;
      hz.flushE   = flush_e;
      hz.flushD   = (hz.jumpD || hz.pcsrcD) && !stall_fd;
   end

`ifdef HAZARD_PERF_CNT_EN
   // Saturating counters of stalled-fetch and E-flush cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_cycles <= '0;
      end else begin
         if (stall_fd && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
         if (flush_e  && (flush_cycles != '1)) flush_cycles <= flush_cycles + 32'd1;
      end
   end
`endif

endmodule
